bcd_digit_converter: RTL

- Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 4-digit seven-segment display driver. Its 16-bit packed BCD output feeds that driver's `digits` input, so binary values from the datapath show in decimal.
- Holds the last completed result stable between conversions so the display never shows partial values.

---
 rtl/bcd_digit_converter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bcd_digit_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Inputs above 9999 are clamped to 9999 and flagged. The last result holds between conversions.
module bcd_digit_converter #(
  parameter int unsigned IN_WIDTH = 14
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] binIn,
  output logic                busy,
  output logic                done,
  output logic [15:0]         digits,
  output logic                overflow
);

  localparam int unsigned CNT_W  = $clog2(IN_WIDTH);
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned EXT_W  = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1
  } state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] operand_q, operand_d;
  logic [BCD_W-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BCD_W-1:0]    digits_q, digits_d;
  logic                overflow_q, overflow_d;

  logic [EXT_W-1:0]    bin_ext;
  logic [BCD_W-1:0]    adj;

  assign bin_ext = EXT_W'(binIn);

  // State and datapath registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      operand_q  <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state, iteration datapath and output logic
  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    digits_d   = digits_q;
    overflow_d = overflow_q;

    // Add 3 to each nibble that is >= 5, independently (no inter-nibble carry)
    adj = scratch_q;
    for (int n = 0; n < 4; n++) begin
      if (scratch_q[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (bin_ext > EXT_W'(9999)) begin
            operand_d = IN_WIDTH'(EXT_W'(9999));
            ovf_d     = 1'b1;
          end else begin
            operand_d = binIn;
            ovf_d     = 1'b0;
          end
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        scratch_d = BCD_W'({adj, operand_q[IN_WIDTH-1]});
        operand_d = {operand_q[IN_WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
          digits_d   = scratch_d;
          overflow_d = ovf_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign digits   = digits_q;
  assign overflow = overflow_q;

endmodule
